// File: rtl/morph_program_engine.sv
// rtl/morph_program_engine.sv - loadable binary-morphology program engine with streamed result
// Runs up to ProgramDepth opcodes on a captured image, then emits the accumulator MSB-first.
module morph_program_engine #(
  parameter int ImageWidth   = 8,
  parameter int ImageHeight  = 4,
  parameter int ProgramDepth = 4,
  parameter int AddrWidth    = 2,
  parameter int WordWidth    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              prog_we,
  input  logic [AddrWidth-1:0]              prog_addr,
  input  logic [15:0]                       prog_data,
  input  logic [AddrWidth:0]                prog_len,
  input  logic                              start,
  input  logic [ImageWidth*ImageHeight-1:0] image_in,
  output logic                              busy,
  output logic                              done,
  output logic [WordWidth-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ImageWidth*ImageHeight-1:0] result
);

  localparam int NPix     = ImageWidth * ImageHeight;
  localparam int Words    = NPix / WordWidth;
  localparam int KWidth   = (Words > 1) ? $clog2(Words) : 1;
  localparam int IdxWidth = (NPix > 1) ? $clog2(NPix) : 1;
  localparam logic [AddrWidth:0] DepthLen = (AddrWidth + 1)'(ProgramDepth);
  localparam logic [KWidth-1:0]  LastWord = KWidth'(Words - 1);

  typedef enum logic [1:0] {IDLE, EXEC, STREAM} state_e;

  state_e               state_q, state_d;
  logic [15:0]          mem_q [ProgramDepth];
  logic [15:0]          mem_d [ProgramDepth];
  logic [NPix-1:0]      img_q, img_d, acc_q, acc_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth:0]   len_q, len_d, eff_len;
  logic [KWidth-1:0]    k_q, k_d;
  logic                 done_q, done_d;

  logic [15:0]          op;
  logic [8:0]           el;
  logic [NPix-1:0]      src, dil, ero, morph_res, logic_res;
  logic [WordWidth-1:0] word;
  logic                 nb;
  int                   nr, nc;

  // Neighbourhood evaluation over the whole image; out-of-image neighbours read 0.
  always_comb begin
    op  = mem_q[pc_q];
    el  = op[15:7];
    src = op[3] ? img_q : acc_q;
    dil = '0;
    ero = '1;
    nb  = 1'b0;
    nr  = 0;
    nc  = 0;
    for (int r = 0; r < ImageHeight; r++) begin
      for (int c = 0; c < ImageWidth; c++) begin
        for (int j = 0; j < 9; j++) begin
          if (el[4'(8 - j)]) begin
            nr = r + j / 3 - 1;
            nc = c + j % 3 - 1;
            nb = 1'b0;
            if (nr >= 0 && nr < ImageHeight && nc >= 0 && nc < ImageWidth)
              nb = src[IdxWidth'(NPix - 1 - (nr * ImageWidth + nc))];
            dil[IdxWidth'(NPix - 1 - (r * ImageWidth + c))] =
              dil[IdxWidth'(NPix - 1 - (r * ImageWidth + c))] | nb;
            ero[IdxWidth'(NPix - 1 - (r * ImageWidth + c))] =
              ero[IdxWidth'(NPix - 1 - (r * ImageWidth + c))] & nb;
          end
        end
      end
    end
    case (op[6:4])
      3'b001:  morph_res = dil;
      3'b010:  morph_res = ero;
      3'b011:  morph_res = ~src;
      default: morph_res = src;
    endcase
    case (op[2:0])
      3'b001:  logic_res = acc_q | morph_res;
      3'b010:  logic_res = acc_q & morph_res;
      3'b011:  logic_res = acc_q ^ morph_res;
      3'b100:  logic_res = acc_q & ~morph_res;
      default: logic_res = morph_res;
    endcase
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < Words; i++)
      if (k_q == KWidth'(i)) word = acc_q[NPix - 1 - i * WordWidth -: WordWidth];
  end

  assign eff_len = (prog_len > DepthLen) ? DepthLen : prog_len;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    img_d   = img_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    len_d   = len_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (prog_we) mem_d[prog_addr] = prog_data;
        if (start) begin
          img_d   = image_in;
          acc_d   = image_in;
          pc_d    = '0;
          k_d     = '0;
          len_d   = eff_len;
          state_d = (eff_len == '0) ? STREAM : EXEC;
        end
      end
      EXEC: begin
        acc_d = logic_res;
        pc_d  = pc_q + 1'b1;
        if ({1'b0, pc_q} == len_q - 1'b1) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (k_q == LastWord) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < ProgramDepth; i++) mem_q[i] <= '0;
      img_q   <= '0;
      acc_q   <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      img_q   <= img_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_data  = (state_q == STREAM) ? word : '0;
  assign done      = done_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_morph_program_engine.sv
// tb/tb_morph_program_engine.sv - self-checking bench for morph_program_engine
module tb_morph_program_engine;

  localparam int W = 8, H = 4, N = 32, WW = 8, WORDS = 4, AW = 2, PD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [N-1:0]  image_in = '0;
  logic          busy, done, out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_data;
  logic [N-1:0]  result;

  morph_program_engine #(
    .ImageWidth(W), .ImageHeight(H), .ProgramDepth(PD), .AddrWidth(AW), .WordWidth(WW)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .image_in(image_in), .busy(busy), .done(done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: program memory shadow and pixel-level image arithmetic.
  logic [15:0]  shadow [PD];
  logic [N-1:0] m_result = '0;
  bit           m_busy = 0, m_done = 0;
  int           m_k = 0, m_t0 = 0, m_stream_at = 0, m_len = 0, cyc = 0;

  function automatic bit px(input logic [N-1:0] s, input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
    return s[N-1-(r*W+c)];
  endfunction

  function automatic logic [N-1:0] model_run(input logic [N-1:0] img, input int len);
    logic [N-1:0] a, s, m;
    logic [15:0] o;
    bit any, all, e;
    a = img;
    for (int i = 0; i < len; i++) begin
      o = shadow[i];
      s = o[3] ? img : a;
      m = '0;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          any = 0; all = 1;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              e = o[15 - ((dr + 1) * 3 + (dc + 1))];
              if (e) begin
                any = any | px(s, r + dr, c + dc);
                all = all & px(s, r + dr, c + dc);
              end
            end
          case (o[6:4])
            3'd1: m[N-1-(r*W+c)] = any;
            3'd2: m[N-1-(r*W+c)] = all;
            3'd3: m[N-1-(r*W+c)] = ~px(s, r, c);
            default: m[N-1-(r*W+c)] = px(s, r, c);
          endcase
        end
      case (o[2:0])
        3'd1: a = a | m;
        3'd2: a = a & m;
        3'd3: a = a ^ m;
        3'd4: a = a & ~m;
        default: a = m;
      endcase
    end
    return a;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PD; i++) shadow[i] = '0;
      m_busy = 0; m_done = 0; m_k = 0; m_result = '0;
    end else begin
      cyc++;
      m_done = 0;
      if (!m_busy) begin
        if (prog_we) shadow[prog_addr] = prog_data;
        if (start) begin
          m_len = (prog_len > PD) ? PD : int'(prog_len);
          m_result = model_run(image_in, m_len);
          m_t0 = cyc;
          m_stream_at = cyc + m_len;
          m_k = 0;
          m_busy = 1;
        end
      end else if (cyc > m_stream_at && out_ready) begin
        m_k++;
        if (m_k == WORDS) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  end

  bit         exp_valid;
  logic [7:0] exp_word;
  always @(negedge clk) begin
    if (rst) begin
      exp_valid = m_busy && (cyc >= m_stream_at);
      exp_word  = exp_valid ? m_result[N-1-8*m_k -: 8] : 8'h00;
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, exp_valid);
      chk("out_data", out_data, exp_word);
      chk("done", done, m_done);
      if (!m_busy || exp_valid) chk("result", result, m_result);
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  task automatic start_run(input logic [AW:0] len);
    got.delete();
    prog_len = len; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, done, 1);
    lat = cyc - m_t0;
  endtask

  task automatic check_words(input string nm, input logic [31:0] exp);
    chk({nm, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk({nm, "_word"}, got[i], exp[31-8*i -: 8]);
  endtask

  localparam logic [31:0] IMG = 32'h00301800;
  int lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_result", result, 0);
    rst = 1;
    @(posedge clk); #1;

    // dilate by a cross
    image_in = IMG; out_ready = 1;
    wr(0, 16'h5D10);
    start_run(1);
    wait_done("t1", lat);
    check_words("t1", 32'h30783C18);
    chk("t1_latency", lat, 5);

    // erode of original is empty, so A & ~M keeps A; later image_in changes are ignored
    wr(1, 16'h5D2C);
    start_run(2);
    image_in = 32'hFFFF_FFFF;
    wait_done("t2", lat);
    check_words("t2", 32'h30783C18);
    chk("t2_latency", lat, 6);
    image_in = IMG;

    // zero-length program passes the image straight through
    start_run(0);
    chk("t3_valid_early", out_valid, 1);
    wait_done("t3", lat);
    check_words("t3", IMG);
    chk("t3_latency", lat, 4);

    // backpressure mid-stream
    start_run(1);
    lat = 0;
    while (got.size() < 2 && lat < 50) begin @(posedge clk); #1; lat++; end
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold", out_data, 8'h3C);
    end
    out_ready = 1;
    wait_done("t4", lat);
    check_words("t4", 32'h30783C18);

    // writes and start during STREAM are ignored
    start_run(1);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    prog_we = 1; prog_addr = 0; prog_data = 16'hFFFF; start = 1;
    @(posedge clk); #1;
    prog_we = 0; start = 0;
    wait_done("t5", lat);
    check_words("t5", 32'h30783C18);
    @(posedge clk); #1;
    start_run(1);
    wait_done("t5r", lat);
    check_words("t5r", 32'h30783C18);
    chk("t5r_latency", lat, 5);

    // write coincident with start is visible; prog_len above depth clamps
    got.delete();
    prog_we = 1; prog_addr = 3; prog_data = 16'h0030; prog_len = 3'd7; start = 1;
    @(posedge clk); #1;
    prog_we = 0; start = 0;
    wait_done("t6", lat);
    check_words("t6", 32'hCF87C3E7);
    chk("t6_latency", lat, 8);

    // asynchronous reset during EXEC
    @(posedge clk); #1;
    start_run(4);
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_valid", out_valid, 0);
    chk("t7_data", out_data, 0);
    chk("t7_done", done, 0);
    chk("t7_result", result, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    start_run(2);
    wait_done("t7", lat);
    check_words("t7", IMG);
    chk("t7_latency", lat, 6);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
